// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-requester round-robin grant arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Why a grant ended; done wins over a request drop, which wins over the hold limit.
    typedef enum logic [1:0] {
        REL_NONE    = 2'd0,
        REL_DONE    = 2'd1,
        REL_DROP    = 2'd2,
        REL_TIMEOUT = 2'd3
    } rel_cause_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: rotate by ptr, find first, un-rotate.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    // Scan downward so the lowest asserted offset from ptr is the one kept.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign winner = off + ptr;
    assign any    = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter feeding a 2-to-4 enable decoder; grants are held until
// done, request drop or hold limit, always followed by a one-cycle idle gap.
//
// state | meaning
// IDLE  | no owner, decoder disabled; next edge grants the round-robin winner
// GRANT | owner drives decoder; released on done, request drop or hold limit
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt, hold_d;
    logic [IDX_W-1:0] idx_d;
    logic             valid_d;
    logic             to_d;
    logic [IDX_W-1:0] winner;
    logic             any;
    rel_cause_t       cause;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt    <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt    <= hold_d;
            grant_idx   <= idx_d;
            grant_valid <= valid_d;
            timeout     <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_cnt;
        idx_d   = grant_idx;
        valid_d = grant_valid;
        to_d    = 1'b0;
        cause   = REL_NONE;
        case (state_q)
            IDLE: begin
                if (any) begin
                    idx_d   = winner;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done) begin
                    cause = REL_DONE;
                end else if (!req[grant_idx]) begin
                    cause = REL_DROP;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    cause = REL_TIMEOUT;
                end
                if (hold_cnt != CNT_MAX) begin
                    hold_d = hold_cnt + 1'b1;
                end
                // grant_idx is left as-is on release; the decoder is disabled anyway.
                if (cause != REL_NONE) begin
                    valid_d = 1'b0;
                    ptr_d   = grant_idx + 1'b1;
                    state_d = IDLE;
                    to_d    = (cause == REL_TIMEOUT);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: vector table plus timeout, reset and no-limit sequences.
module tb_rr_grant_arbiter;
    import rr_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req0;
    logic       done, done0;
    logic [1:0] grant_idx, grant_idx0;
    logic       grant_valid, grant_valid0;
    logic       timeout, timeout0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rr_grant_arbiter #(.CNT_W(8), .MAX_HOLD(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    rr_grant_arbiter #(.CNT_W(8), .MAX_HOLD(0)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .req         (req0),
        .done        (done0),
        .grant_idx   (grant_idx0),
        .grant_valid (grant_valid0),
        .timeout     (timeout0)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [3:0] r, input logic d, input logic [1:0] i,
                                input logic v, input logic t);
        vec_t x;
        x.req = r; x.done = d; x.idx = i; x.valid = v; x.to = t;
        vecs.push_back(x);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int bad;

        // Table: inputs applied before an edge, expected registered outputs after it.
        add(4'b1010, 1'b0, 2'd1, 1'b1, 1'b0);
        add(4'b1010, 1'b1, 2'd1, 1'b0, 1'b0);
        add(4'b1010, 1'b0, 2'd3, 1'b1, 1'b0);
        add(4'b1010, 1'b1, 2'd3, 1'b0, 1'b0);
        add(4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            add(4'b1111, 1'b0, 2'(g % 4), 1'b1, 1'b0);
            add(4'b1111, 1'b0, 2'(g % 4), 1'b1, 1'b0);
            add(4'b1111, 1'b0, 2'(g % 4), 1'b1, 1'b0);
            add(4'b1111, 1'b1, 2'(g % 4), 1'b0, 1'b0);
        end
        add(4'b0110, 1'b0, 2'd1, 1'b1, 1'b0);
        add(4'b0100, 1'b0, 2'd1, 1'b0, 1'b0);
        add(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        add(4'b1111, 1'b0, 2'd2, 1'b1, 1'b0);
        add(4'b0101, 1'b0, 2'd2, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);

        rst = 1'b1; req = '0; done = 1'b0; req0 = '0; done0 = 1'b0;
        repeat (2) tick();
        chk("reset idx", grant_idx, 0);
        chk("reset valid", grant_valid, 0);
        chk("reset timeout", timeout, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle%0d valid", i), grant_valid, 0);
            chk($sformatf("idle%0d timeout", i), timeout, 0);
        end

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            chk($sformatf("vec%0d idx", i), grant_idx, vecs[i].idx);
            chk($sformatf("vec%0d valid", i), grant_valid, vecs[i].valid);
            chk($sformatf("vec%0d timeout", i), timeout, vecs[i].to);
        end

        // Hold limit: ptr=3, only requester 2 asking, never releases on its own.
        req = 4'b0100; done = 1'b0;
        tick();
        chk("to first idx", grant_idx, 2);
        hi = 0;
        while (grant_valid && hi < 40) begin
            hi++;
            tick();
        end
        chk("to grant length", hi, 16);
        chk("to pulse", timeout, 1);
        chk("to gap valid", grant_valid, 0);
        tick();
        chk("to regrant valid", grant_valid, 1);
        chk("to regrant idx", grant_idx, 2);
        chk("to pulse width", timeout, 0);

        // done coinciding with the hold limit is a normal release.
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("coinc hold%0d valid", i), grant_valid, 1);
        end
        done = 1'b1;
        tick();
        chk("coinc release valid", grant_valid, 0);
        chk("coinc no timeout", timeout, 0);
        done = 1'b0; req = '0;
        tick();
        chk("coinc after timeout", timeout, 0);

        // Reset mid-grant, ptr=3 so 4'b1001 picks 3 before reset and 0 after.
        req = 4'b1001;
        tick();
        chk("pre-rst idx", grant_idx, 3);
        chk("pre-rst valid", grant_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", grant_valid, 0);
        chk("async rst idx", grant_idx, 0);
        chk("async rst timeout", timeout, 0);
        #1 rst = 1'b0;
        tick();
        chk("post-rst idx", grant_idx, 0);
        chk("post-rst valid", grant_valid, 1);
        chk("post-rst timeout", timeout, 0);
        done = 1'b1;
        tick();
        chk("post-rst release", grant_valid, 0);
        done = 1'b0; req = '0;

        // No hold limit: grant persists and the counter saturates.
        req0 = 4'b0001;
        tick();
        chk("nolimit valid", grant_valid0, 1);
        chk("nolimit idx", grant_idx0, 0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (grant_valid0 !== 1'b1 || timeout0 !== 1'b0) bad++;
        end
        chk("nolimit held", bad, 0);
        chk("nolimit saturate", u_dut0.hold_cnt, 255);
        req0 = '0;
        tick();
        chk("nolimit drop", grant_valid0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
